// File: rtl/ex_issue_stage.sv
// ex_issue_stage: registers one decoded instruction for the ALU, forms its
// operands (with optional EX/MEM and MEM/WB forwarding) and decodes the
// 4-bit ALU opcode. A stalled instruction keeps re-forwarding its operands
// so that late writebacks to its source registers are not lost.
module ex_issue_stage #(
    parameter bit FWD_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_alu_op,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7_5,
    input  logic        in_alu_src,
    input  logic        in_reg_write,
    input  logic        ex_stall,
    input  logic        flush,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUControl,
    output logic [31:0] out_pc,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [31:0] issue_count
);

    // Pick the newest in-flight value for a source register; x0 is never
    // forwarded, and EX/MEM is younger than MEM/WB so it wins a double match.
    function automatic logic [31:0] fwd_value(
        input logic [4:0]  rs,
        input logic [31:0] fallback,
        input logic        e_we,
        input logic [4:0]  e_rd,
        input logic [31:0] e_res,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_res
    );
        logic [31:0] v;
        if (FWD_ENABLE && e_we && (e_rd != 5'd0) && (e_rd == rs)) begin
            v = e_res;
        end else if (FWD_ENABLE && m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            v = m_res;
        end else begin
            v = fallback;
        end
        return v;
    endfunction

    // Map operation class and function bits to the ALU opcode.
    function automatic logic [3:0] alu_decode(
        input logic [1:0] op,
        input logic [2:0] f3,
        input logic       f7_5
    );
        logic [3:0] c;
        case (op)
            2'b00: c = 4'b0010;
            2'b01: begin
                case (f3[2:1])
                    2'b00:   c = 4'b0110;
                    2'b10:   c = 4'b0111;
                    2'b11:   c = 4'b1000;
                    default: c = 4'b0110;
                endcase
            end
            2'b10, 2'b11: begin
                case (f3)
                    3'b000:  c = ((op == 2'b10) && f7_5) ? 4'b0110 : 4'b0010;
                    3'b001:  c = 4'b0100;
                    3'b010:  c = 4'b0111;
                    3'b011:  c = 4'b1000;
                    3'b100:  c = 4'b0011;
                    3'b101:  c = f7_5 ? 4'b1101 : 4'b0101;
                    3'b110:  c = 4'b0001;
                    3'b111:  c = 4'b0000;
                    default: c = 4'b0010;
                endcase
            end
            default: c = 4'b0010;
        endcase
        return c;
    endfunction

    logic        out_valid_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [3:0]  alu_ctrl_r;
    logic [31:0] pc_r;
    logic [31:0] store_data_r;
    logic [4:0]  rd_r;
    logic        reg_write_r;
    logic [31:0] issue_count_r;
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;
    logic        alu_src_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        hold_s;
    logic [31:0] rs1_fwd_s;
    logic [31:0] rs2_fwd_s;
    logic [31:0] rs1_hold_fwd_s;
    logic [31:0] rs2_hold_fwd_s;
    logic [3:0]  alu_ctrl_s;

    // Handshake, operand forwarding for the incoming and the held instruction.
    always_comb begin
        in_ready_s     = !out_valid_r || !ex_stall;
        accept_s       = in_valid && in_ready_s && !flush;
        hold_s         = out_valid_r && ex_stall && !flush;
        rs1_fwd_s      = fwd_value(in_rs1, in_rs1_data, exm_reg_write, exm_rd, exm_result,
                                   mwb_reg_write, mwb_rd, mwb_result);
        rs2_fwd_s      = fwd_value(in_rs2, in_rs2_data, exm_reg_write, exm_rd, exm_result,
                                   mwb_reg_write, mwb_rd, mwb_result);
        rs1_hold_fwd_s = fwd_value(rs1_r, a_r, exm_reg_write, exm_rd, exm_result,
                                   mwb_reg_write, mwb_rd, mwb_result);
        rs2_hold_fwd_s = fwd_value(rs2_r, store_data_r, exm_reg_write, exm_rd, exm_result,
                                   mwb_reg_write, mwb_rd, mwb_result);
        alu_ctrl_s     = alu_decode(in_alu_op, in_funct3, in_funct7_5);
    end

    // Pipeline register: flush beats accept beats stall-refresh; an empty
    // slot never advertises a register write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            alu_ctrl_r    <= 4'd0;
            pc_r          <= 32'd0;
            store_data_r  <= 32'd0;
            rd_r          <= 5'd0;
            reg_write_r   <= 1'b0;
            issue_count_r <= 32'd0;
            rs1_r         <= 5'd0;
            rs2_r         <= 5'd0;
            alu_src_r     <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            a_r           <= rs1_fwd_s;
            b_r           <= in_alu_src ? in_imm : rs2_fwd_s;
            alu_ctrl_r    <= alu_ctrl_s;
            pc_r          <= in_pc;
            store_data_r  <= rs2_fwd_s;
            rd_r          <= in_rd;
            reg_write_r   <= in_reg_write;
            issue_count_r <= issue_count_r + 32'd1;
            rs1_r         <= in_rs1;
            rs2_r         <= in_rs2;
            alu_src_r     <= in_alu_src;
        end else if (hold_s) begin
            a_r          <= rs1_hold_fwd_s;
            store_data_r <= rs2_hold_fwd_s;
            if (!alu_src_r) begin
                b_r <= rs2_hold_fwd_s;
            end else begin
                b_r <= b_r;
            end
        end else begin
            out_valid_r <= 1'b0;
            reg_write_r <= 1'b0;
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign A              = a_r;
    assign B              = b_r;
    assign ALUControl     = alu_ctrl_r;
    assign out_pc         = pc_r;
    assign out_store_data = store_data_r;
    assign out_rd         = rd_r;
    assign out_reg_write  = reg_write_r;
    assign issue_count    = issue_count_r;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed testbench for ex_issue_stage: inputs driven on the falling edge,
// outputs sampled on the following falling edge.
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct3;
    logic        in_funct7_5, in_alu_src, in_reg_write;
    logic        ex_stall, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        out_valid;
    logic [31:0] A, B, out_pc, out_store_data, issue_count;
    logic [3:0]  ALUControl;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    ex_issue_stage #(.FWD_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
        .ex_stall(ex_stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .out_valid(out_valid), .A(A), .B(B), .ALUControl(ALUControl),
        .out_pc(out_pc), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .issue_count(issue_count)
    );

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = 32'd0; in_rs1_data = 32'd0; in_rs2_data = 32'd0;
        in_imm = 32'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
        in_alu_op = 2'b00; in_funct3 = 3'd0; in_funct7_5 = 1'b0;
        in_alu_src = 1'b0; in_reg_write = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] rd,
                             input logic [31:0] pc);
        in_valid = 1'b1; in_alu_op = op; in_funct3 = f3; in_funct7_5 = f7;
        in_alu_src = src; in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = d1;
        in_rs2_data = d2; in_imm = imm; in_rd = rd; in_pc = pc; in_reg_write = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
        total++; if (A !== 32'd0 || B !== 32'd0) begin bad++; $display("FAIL rst_ab got=%0h/%0h exp=0", A, B); end
        total++; if (ALUControl !== 4'd0 || issue_count !== 32'd0) begin bad++; $display("FAIL rst_ctl got=%0h/%0h exp=0", ALUControl, issue_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL post_rst got rdy=%0h vld=%0h exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_rtype_sub();
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 5'd7, 32'h100);
        @(negedge clk); exp_count++;
        idle_inputs();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_valid got=%0h exp=1", out_valid); end
        total++; if (A !== 32'd10 || B !== 32'd3) begin bad++; $display("FAIL sub_ab got=%0d/%0d exp=10/3", A, B); end
        total++; if (ALUControl !== 4'b0110) begin bad++; $display("FAIL sub_ctl got=%b exp=0110", ALUControl); end
        total++; if (issue_count !== exp_count) begin bad++; $display("FAIL sub_cnt got=%0d exp=%0d", issue_count, exp_count); end
        total++; if (out_rd !== 5'd7 || out_pc !== 32'h100 || out_reg_write !== 1'b1) begin bad++; $display("FAIL sub_side got rd=%0d pc=%0h rw=%0h", out_rd, out_pc, out_reg_write); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || A !== 32'd10) begin bad++; $display("FAIL bubble got vld=%0h rw=%0h A=%0d exp 0/0/10", out_valid, out_reg_write, A); end
    endtask

    task automatic test_forward();
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 5'd5, 5'd9, 32'h1, 32'h2, 32'd0, 5'd3, 32'h200);
        exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h11;
        mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'h22;
        @(negedge clk); exp_count++;
        total++; if (A !== 32'h11) begin bad++; $display("FAIL fwd_exm got=%0h exp=11", A); end
        total++; if (B !== 32'h2) begin bad++; $display("FAIL fwd_nomatch got=%0h exp=2", B); end
        in_rs1 = 5'd0; in_rs1_data = 32'h33; exm_rd = 5'd0; mwb_rd = 5'd9;
        @(negedge clk); exp_count++;
        total++; if (A !== 32'h33) begin bad++; $display("FAIL fwd_x0 got=%0h exp=33", A); end
        total++; if (B !== 32'h22 || out_store_data !== 32'h22) begin bad++; $display("FAIL fwd_mwb got=%0h/%0h exp=22", B, out_store_data); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_decode();
        logic [1:0] ops [6] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10};
        logic [2:0] f3s [6] = '{3'b101, 3'b110, 3'b000, 3'b010, 3'b000, 3'b110};
        logic       f7s [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp [6] = '{4'b1101, 4'b1000, 4'b0110, 4'b0010, 4'b0010, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            set_instr(ops[i], f3s[i], f7s[i], 1'b1, 5'd1, 5'd2, 32'd7, 32'd8, 32'd4, 5'd1, 32'h300);
            @(negedge clk); exp_count++;
            total++; if (ALUControl !== exp[i]) begin bad++; $display("FAIL dec%0d got=%b exp=%b", i, ALUControl, exp[i]); end
        end
        total++; if (B !== 32'd4 || out_store_data !== 32'd8) begin bad++; $display("FAIL imm_b got=%0d/%0d exp=4/8", B, out_store_data); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_stall();
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd4, 32'h50, 32'h60, 32'd0, 5'd2, 32'h400);
        @(negedge clk); exp_count++;
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 5'd6, 5'd7, 32'h99, 32'h98, 32'd0, 5'd9, 32'h500);
        ex_stall = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0h exp=0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_result = 32'hABC; end
            else begin mwb_reg_write = 1'b0; end
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || ALUControl !== 4'b0010 || issue_count !== exp_count) begin bad++; $display("FAIL stall_hold%0d got vld=%0h pc=%0h ctl=%b cnt=%0d", c, out_valid, out_pc, ALUControl, issue_count); end
            total++; if (A !== ((c == 0) ? 32'h50 : 32'hABC) || B !== 32'h60) begin bad++; $display("FAIL stall_ops%0d got A=%0h B=%0h", c, A, B); end
        end
        idle_inputs();
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || issue_count !== exp_count) begin bad++; $display("FAIL stall_release got vld=%0h cnt=%0d exp 0/%0d", out_valid, issue_count, exp_count); end
    endtask

    task automatic test_flush();
        set_instr(2'b00, 3'b010, 1'b0, 1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd16, 5'd4, 32'h600);
        @(negedge clk); exp_count++;
        in_pc = 32'h604; flush = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h/%0h exp=0/0", out_valid, out_reg_write); end
        total++; if (issue_count !== exp_count || out_pc !== 32'h600) begin bad++; $display("FAIL flush_cnt got=%0d pc=%0h exp=%0d/600", issue_count, out_pc, exp_count); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        set_instr(2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 5'd2, 32'h77, 32'h88, 32'd0, 5'd5, 32'h700);
        @(negedge clk);
        ex_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0 || out_pc !== 32'd0) begin bad++; $display("FAIL arst_a got vld=%0h A=%0h B=%0h pc=%0h", out_valid, A, B, out_pc); end
        total++; if (ALUControl !== 4'd0 || out_store_data !== 32'd0 || out_rd !== 5'd0 || out_reg_write !== 1'b0 || issue_count !== 32'd0) begin bad++; $display("FAIL arst_b got ctl=%0h sd=%0h rd=%0h rw=%0h cnt=%0h", ALUControl, out_store_data, out_rd, out_reg_write, issue_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0h exp=1", in_ready); end
        exp_count = 32'd0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        force dut.issue_count_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.issue_count_r;
        #1;
        total++; if (issue_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got=%0h exp=ffffffff", issue_count); end
        set_instr(2'b00, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd1, 5'd1, 32'h800);
        @(negedge clk);
        idle_inputs();
        total++; if (issue_count !== 32'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL wrap got cnt=%0h vld=%0h exp 0/1", issue_count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_forward();
        test_decode();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 Parameter FWD_ENABLE, default 1, meaning: 1 enables EX/MEM and MEM/WB operand forwarding; 0 uses register-file data only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  decode-side handshake.
REQ-005 in_pc, in_rs1_data, in_rs2_data, in_imm  input  32 each  decoded instruction data.
REQ-006 in_rs1, in_rs2, in_rd  input  5 each  register indices.
REQ-007 in_alu_op  input  2  operation class: 00 load/store add, 01 branch, 10 R-type, 11 I-type ALU.
REQ-008 in_funct3 / in_funct7_5  input  3 / 1  instruction function bits; funct7_5 is instr[30].
REQ-009 in_alu_src / in_reg_write  input  1 / 1  B = imm select; instruction writes rd.
REQ-010 ex_stall / flush  input  1 / 1  downstream cannot accept; kill held instruction.
REQ-011 exm_reg_write, exm_rd, exm_result  input  1, 5, 32  EX/MEM writeback source.
REQ-012 mwb_reg_write, mwb_rd, mwb_result  input  1, 5, 32  MEM/WB writeback source.
REQ-013 out_valid  output  1  registered instruction present for the ALU.
REQ-014 A, B  output  32 each  ALU operands, registered.
REQ-015 ALUControl  output  4  ALU opcode, registered.
REQ-016 out_pc, out_store_data, out_rd, out_reg_write  output  32, 32, 5, 1  sideband for later stages.
REQ-017 issue_count  output  32  number of instructions accepted since reset.

Function
REQ-018 in_ready SHALL equal !out_valid || !ex_stall, combinationally.
REQ-019 Accept occurs when in_valid && in_ready && !flush; on accept all output registers load next state and out_valid=1 at the next edge (1-cycle latency).
REQ-020 When in_ready && !accept, out_valid SHALL go 0; other outputs hold their values.
REQ-021 flush SHALL take priority over accept and stall: next edge out_valid=0, no instruction captured, issue_count unchanged.
REQ-022 When out_valid && ex_stall && !flush, all output registers SHALL hold, except A and out_store_data/B, which SHALL refresh per REQ-025 from the held rs1/rs2 indices.
REQ-023 Forwarded rs value: if FWD_ENABLE && exm_reg_write && exm_rd!=0 && exm_rd==rs then exm_result; else if FWD_ENABLE && mwb_reg_write && mwb_rd!=0 && mwb_rd==rs then mwb_result; else register-file value (EX/MEM wins on double match).
REQ-024 Index 0 SHALL never be forwarded; x0 operand is the register-file value.
REQ-025 A = forwarded rs1; out_store_data = forwarded rs2; B = in_alu_src ? in_imm : forwarded rs2. During a stall refresh the register-file fallback SHALL be the held operand value.
REQ-026 ALUControl for alu_op 00: 0010 (ADD).
REQ-027 alu_op 01 (branch): funct3 00x -> 0110 (SUB); 10x -> 0111 (SLT); 11x -> 1000 (SLTU).
REQ-028 alu_op 10/11 by funct3: 000 ADD 0010, or SUB 0110 only for alu_op 10 with funct7_5=1; 001 SLL 0100; 010 SLT 0111; 011 SLTU 1000; 100 XOR 0011; 101 SRL 0101, or SRA 1101 if funct7_5=1; 110 OR 0001; 111 AND 0000.
REQ-029 issue_count SHALL increment by 1 per accept, wrapping from 0xFFFFFFFF to 0.
REQ-030 out_rd, out_reg_write, out_pc SHALL be captured unmodified on accept; out_reg_write SHALL be 0 whenever out_valid=0.

Reset
REQ-031 rst_n low SHALL asynchronously clear out_valid, A, B, ALUControl, out_pc, out_store_data, out_rd, out_reg_write and issue_count to 0.
REQ-032 During and immediately after reset in_ready SHALL be 1; reset asserted mid-stall discards the held instruction.

Verification
REQ-033 R-type SUB, rs1_data=10, rs2_data=3, no forwarding -> next cycle out_valid=1, A=10, B=3, ALUControl=0110, issue_count=1.
REQ-034 rs1=5 with exm_rd=5, exm_result=0x11 and mwb_rd=5, mwb_result=0x22, both writes=1 -> A=0x11; same with rs1=0 -> A=rs1_data.
REQ-035 I-type SRAI (alu_op 11, funct3 101, funct7_5=1, alu_src=1, imm=4) -> ALUControl=1101, B=4; BLTU -> 1000.
REQ-036 out_valid=1, ex_stall=1 for 3 cycles with in_valid=1 -> in_ready=0, outputs held, issue_count unchanged; mwb write to held rs1 mid-stall -> A updates to mwb_result.
REQ-037 flush and accept on the same edge -> out_valid=0, issue_count unchanged; rst_n low mid-stall -> all outputs 0 without a clock edge.
REQ-038 Preload issue_count 0xFFFFFFFF via 2^32-1 accepts (or forced state), one more accept -> issue_count=0.
